posit_add_result_checker: RTL

- Synthesisable stage placed directly downstream of the Optimised_PA posit adder (N=32, ES=2).
- Consumes each adder result together with the golden expected posit and computes the absolute bit-pattern difference.
- Counts mismatches and tracks the worst-case difference and the index of the first error.
- Replaces file-based error logging for on-chip/FPGA regression of the adder over a fixed-length vector stream.

---
 rtl/posit_chk_pkg.sv | 29 ++
 rtl/posit_abs_diff.sv | 18 +
 rtl/posit_add_result_checker.sv | 138 +++++++++++++
 3 files changed

// File: rtl/posit_chk_pkg.sv
// Shared definitions for the posit result checkers: FSM states, posit
// special patterns and the saturating counter helper.
package posit_chk_pkg;

  localparam int POSIT_N  = 32;
  localparam int POSIT_ES = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } chk_state_e;

  // NaR is a single 1 in the MSB followed by zeros, for any width n <= 64.
  function automatic logic [63:0] nar_pattern(input int n);
    return 64'd1 << (n - 1);
  endfunction

  // Increment cnt, holding at the largest value a w-bit counter can hold
  // (w up to 32).
  function automatic logic [31:0] sat_inc(input logic [31:0] cnt, input int w);
    logic [31:0] max_val;
    if (w >= 32) max_val = '1;
    else         max_val = (32'd1 << w) - 32'd1;
    return (cnt == max_val) ? cnt : cnt + 32'd1;
  endfunction

endpackage

// File: rtl/posit_abs_diff.sv
// Absolute difference of two N-bit patterns treated as unsigned integers.
// Never wraps: the smaller operand is always subtracted from the larger.
module posit_abs_diff #(
  parameter int N = 32
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic [N-1:0] diff,
  output logic         neq
);

  // Order the operands before subtracting so the result stays in range
  always_comb begin
    diff = (a > b) ? (a - b) : (b - a);
    neq  = (a != b);
  end

endmodule

// File: rtl/posit_add_result_checker.sv
// On-chip checker for the posit adder output stream. Each accepted
// dut_out/expected pair is registered, its absolute bit-pattern distance is
// retired one cycle later, and per-run statistics are accumulated: mismatch
// count (saturating), worst-case distance and index of the first mismatch.
module posit_add_result_checker
  import posit_chk_pkg::*;
#(
  parameter int N           = 32,
  parameter int ES          = 2,
  parameter int NUM_VECTORS = 65535,
  parameter int IDX_W       = 16,
  parameter int ERR_W       = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N-1:0]     dut_out,
  input  logic [N-1:0]     expected,
  output logic [N-1:0]     diff_out,
  output logic             diff_valid,
  output logic [IDX_W-1:0] vec_count,
  output logic [ERR_W-1:0] error_count,
  output logic             first_err_valid,
  output logic [IDX_W-1:0] first_err_idx,
  output logic [N-1:0]     max_diff,
  output logic             busy,
  output logic             done
);

  if (NUM_VECTORS < 1 || NUM_VECTORS > (2**IDX_W) - 1 ||
      ES < 0 || ES > N - 3 || ERR_W < 1 || ERR_W > 32) begin : g_bad_cfg
    $error("posit_add_result_checker: illegal parameter combination");
  end

  chk_state_e state_q, state_d;

  logic             accept;
  logic             last_accept;
  logic             clear_stats;

  logic [N-1:0]     exp_p1;
  logic [N-1:0]     dut_p1;
  logic [IDX_W-1:0] idx_p1;
  logic             vld_p1;

  logic [N-1:0]     diff_p1;
  logic             neq_p1;

  assign in_ready    = (state_q == RUN);
  assign accept      = in_valid && in_ready;
  assign last_accept = accept && (vec_count == IDX_W'(NUM_VECTORS - 1));
  assign clear_stats = start && ((state_q == IDLE) || (state_q == DONE));
  assign busy        = (state_q == RUN) || (state_q == DRAIN);
  assign done        = (state_q == DONE);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic; DRAIN lasts exactly one cycle because the final
  // sample is always sitting in stage 1 when DRAIN is entered.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (last_accept) state_d = DRAIN;
      DRAIN:   state_d = DONE;
      DONE:    if (start) state_d = RUN;
      default: state_d = IDLE;
    endcase
  end

  // Accepted-sample counter, cleared when a new run is launched
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)           vec_count <= '0;
    else if (clear_stats) vec_count <= '0;
    else if (accept)      vec_count <= vec_count + IDX_W'(1);
  end

  // ---- stage 1: capture the accepted pair and its run index ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_p1 <= '0;
      dut_p1 <= '0;
      idx_p1 <= '0;
      vld_p1 <= 1'b0;
    end else begin
      vld_p1 <= accept;
      if (accept) begin
        exp_p1 <= expected;
        dut_p1 <= dut_out;
        idx_p1 <= vec_count;
      end
    end
  end

  posit_abs_diff #(.N(N)) u_abs_diff (
    .a    (exp_p1),
    .b    (dut_p1),
    .diff (diff_p1),
    .neq  (neq_p1)
  );

  // ---- stage 2: retire the stage-1 sample into diff_out and the run statistics ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      diff_out        <= '0;
      diff_valid      <= 1'b0;
      error_count     <= '0;
      first_err_valid <= 1'b0;
      first_err_idx   <= '0;
      max_diff        <= '0;
    end else begin
      diff_valid <= vld_p1;
      if (clear_stats) begin
        error_count     <= '0;
        first_err_valid <= 1'b0;
        first_err_idx   <= '0;
        max_diff        <= '0;
      end else if (vld_p1) begin
        diff_out <= diff_p1;
        if (neq_p1) begin
          error_count <= ERR_W'(sat_inc(32'(error_count), ERR_W));
          if (!first_err_valid) begin
            first_err_valid <= 1'b1;
            first_err_idx   <= idx_p1;
          end
        end
        if (diff_p1 > max_diff) max_diff <= diff_p1;
      end
    end
  end

endmodule
